// File: rtl/door_pkg.sv
// Shared types and constants for the door controller: FSM states, stage codes
// and saturating stage arithmetic.
package door_pkg;

  typedef enum logic [1:0] {
    ST_CLOSED,
    ST_OPENING,
    ST_OPEN,
    ST_CLOSING
  } door_state_t;

  localparam logic [1:0] STAGE_CLOSED = 2'b00;
  localparam logic [1:0] STAGE_OPEN   = 2'b11;

  function automatic logic [1:0] stage_inc(input logic [1:0] s);
    return (s == STAGE_OPEN) ? STAGE_OPEN : s + 2'b01;
  endfunction

  function automatic logic [1:0] stage_dec(input logic [1:0] s);
    return (s == STAGE_CLOSED) ? STAGE_CLOSED : s - 2'b01;
  endfunction

endpackage

// File: rtl/door_ctrl_tick_timer.sv
// Free-running cycle counter with synchronous clear; done flags the terminal
// count so the caller can act on the same edge that would wrap the period.
module tick_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign done = enable && (r_count == term);

endmodule

// File: rtl/door_ctrl.sv
// Elevator door controller: stepped open/close with dwell, reversal and close
// button. Define DOOR_OBSTRUCT_EN to let the obstruction sensor act.
module door_ctrl
  import door_pkg::*;
#(
  parameter int STEP_TICKS = 4,
  parameter int HOLD_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       openReq,
  input  logic       closeReq,
  input  logic       obstruct,
  input  logic       moving,
  output logic [1:0] dispStage,
  output logic       doorClosed,
  output logic       closeDone
);

  localparam int MAX_TICKS = (STEP_TICKS > HOLD_TICKS) ? STEP_TICKS : HOLD_TICKS;
  localparam int TW = $clog2(MAX_TICKS) + 1;
  localparam logic [TW-1:0] STEP_TERM = TW'(STEP_TICKS - 1);
  localparam logic [TW-1:0] HOLD_TERM = TW'(HOLD_TICKS - 1);

  door_state_t r_state;
  logic [1:0]  r_stage;
  logic        r_closed;
  logic        r_close_done;

  logic          w_obs;
  logic          w_done;
  logic          w_clr;
  logic          w_en;
  logic [TW-1:0] w_term;

`ifdef DOOR_OBSTRUCT_EN
  assign w_obs = obstruct;
`else
  logic w_unused_obstruct;
  assign w_unused_obstruct = obstruct;
  assign w_obs = 1'b0;
`endif

  // Clear whenever the FSM will change state or restart its current period.
  always_comb begin
    w_clr  = 1'b0;
    w_en   = (r_state != ST_CLOSED);
    w_term = (r_state == ST_OPEN) ? HOLD_TERM : STEP_TERM;
    unique case (r_state)
      ST_CLOSED:  w_clr = 1'b1;
      ST_OPENING: w_clr = w_done;
      ST_OPEN:    w_clr = openReq | w_obs | closeReq | w_done;
      ST_CLOSING: w_clr = openReq | w_obs | w_done;
      default:    w_clr = 1'b1;
    endcase
  end

  tick_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clr),
    .enable (w_en),
    .term   (w_term),
    .done   (w_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_CLOSED;
      r_stage      <= STAGE_CLOSED;
      r_closed     <= 1'b1;
      r_close_done <= 1'b0;
    end else begin
      r_close_done <= 1'b0;
      unique case (r_state)
        ST_CLOSED: begin
          if (openReq && !moving) begin
            r_state  <= ST_OPENING;
            r_closed <= 1'b0;
          end
        end
        ST_OPENING: begin
          if (w_done) begin
            r_stage <= stage_inc(r_stage);
            if (stage_inc(r_stage) == STAGE_OPEN) r_state <= ST_OPEN;
          end
        end
        ST_OPEN: begin
          // openReq wins over closeReq; it only restarts the dwell.
          if (!(openReq || w_obs) && (closeReq || w_done)) r_state <= ST_CLOSING;
        end
        ST_CLOSING: begin
          if (openReq || w_obs) begin
            r_state <= ST_OPENING;
          end else if (w_done) begin
            r_stage <= stage_dec(r_stage);
            if (stage_dec(r_stage) == STAGE_CLOSED) begin
              r_state      <= ST_CLOSED;
              r_closed     <= 1'b1;
              r_close_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= ST_CLOSED;
          r_stage  <= STAGE_CLOSED;
          r_closed <= 1'b1;
        end
      endcase
    end
  end

  assign dispStage  = r_stage;
  assign doorClosed = r_closed;
  assign closeDone  = r_close_done;

endmodule

// File: tb/tb_door_ctrl.sv
// Directed bench for door_ctrl: table-driven open cycle plus hand sequences
// for inhibit, reversal, close button, obstruction and async reset.
module tb_door_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       openReq = 1'b0;
  logic       closeReq = 1'b0;
  logic       obstruct = 1'b0;
  logic       moving = 1'b0;
  logic [1:0] dispStage;
  logic       doorClosed;
  logic       closeDone;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  door_ctrl #(.STEP_TICKS(4), .HOLD_TICKS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .openReq    (openReq),
    .closeReq   (closeReq),
    .obstruct   (obstruct),
    .moving     (moving),
    .dispStage  (dispStage),
    .doorClosed (doorClosed),
    .closeDone  (closeDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [1:0] stage;
    logic       closed;
    logic       done;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end else begin
      $display("ok   %s cyc=%0d value=%0d", name, cyc, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Reset, then pulse openReq for one edge; that edge is cycle 0.
  task automatic reset_and_open();
    rst = 1'b1; openReq = 1'b0; closeReq = 1'b0; obstruct = 1'b0; moving = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    openReq = 1'b1;
    @(posedge clk); #1;
    openReq = 1'b0;
    cyc = 0;
  endtask

  vec_t vecs[13];
  int   seen_done;

  initial begin
    vecs[0]  = '{0,  2'b00, 1'b0, 1'b0};
    vecs[1]  = '{3,  2'b00, 1'b0, 1'b0};
    vecs[2]  = '{4,  2'b01, 1'b0, 1'b0};
    vecs[3]  = '{7,  2'b01, 1'b0, 1'b0};
    vecs[4]  = '{8,  2'b10, 1'b0, 1'b0};
    vecs[5]  = '{12, 2'b11, 1'b0, 1'b0};
    vecs[6]  = '{27, 2'b11, 1'b0, 1'b0};
    vecs[7]  = '{31, 2'b11, 1'b0, 1'b0};
    vecs[8]  = '{32, 2'b10, 1'b0, 1'b0};
    vecs[9]  = '{36, 2'b01, 1'b0, 1'b0};
    vecs[10] = '{39, 2'b01, 1'b0, 1'b0};
    vecs[11] = '{40, 2'b00, 1'b1, 1'b1};
    vecs[12] = '{41, 2'b00, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stage", dispStage, 0);
    check("reset_closed", doorClosed, 1);
    check("reset_done", closeDone, 0);

    // Full open/dwell/close cycle from the table
    reset_and_open();
    for (int i = 0; i < 13; i++) begin
      run_to(vecs[i].at);
      check($sformatf("cycle_stage@%0d", vecs[i].at), dispStage, vecs[i].stage);
      check($sformatf("cycle_closed@%0d", vecs[i].at), doorClosed, vecs[i].closed);
      check($sformatf("cycle_done@%0d", vecs[i].at), closeDone, vecs[i].done);
    end

    // Moving inhibit: openReq held 50 cycles while moving
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    moving = 1'b1; openReq = 1'b1; cyc = 0;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
        tick();
        if (dispStage != 2'b00 || doorClosed != 1'b1) bad++;
      end
      check("moving_inhibit_bad_cycles", bad, 0);
    end
    moving = 1'b0; openReq = 1'b0;

    // Reversal at stage 10 in CLOSING
    reset_and_open();
    run_to(32);
    check("rev_pre_stage", dispStage, 2);
    openReq = 1'b1;
    tick();
    openReq = 1'b0;
    seen_done = 0;
    while (cyc < 36) begin
      tick();
      if (closeDone) seen_done++;
    end
    check("rev_stage@36", dispStage, 2);
    tick();
    if (closeDone) seen_done++;
    check("rev_stage@37", dispStage, 3);
    check("rev_no_closedone", seen_done, 0);

    // Close button on third OPEN cycle
    reset_and_open();
    run_to(15);
    closeReq = 1'b1;
    tick();
    closeReq = 1'b0;
    run_to(19);
    check("closebtn_stage@19", dispStage, 3);
    tick();
    check("closebtn_stage@20", dispStage, 2);

    // openReq with closeReq in OPEN: stays open, dwell restarted
    reset_and_open();
    run_to(20);
    openReq = 1'b1; closeReq = 1'b1;
    tick();
    openReq = 1'b0; closeReq = 1'b0;
    check("both_stage@21", dispStage, 3);
    run_to(32);
    check("both_stage@32", dispStage, 3);
    run_to(40);
    check("both_stage@40", dispStage, 3);
    tick();
    check("both_stage@41", dispStage, 2);

    // Obstruction during CLOSING
    reset_and_open();
    run_to(32);
    obstruct = 1'b1;
    tick();
    obstruct = 1'b0;
    run_to(37);
`ifdef DOOR_OBSTRUCT_EN
    check("obstruct_stage@37", dispStage, 3);
`else
    check("obstruct_stage@37", dispStage, 1);
`endif

    // Async reset mid-OPENING at stage 10, between edges
    reset_and_open();
    run_to(9);
    check("areset_pre_stage", dispStage, 2);
    #2;
    rst = 1'b1;
    #1;
    check("areset_stage", dispStage, 0);
    check("areset_closed", doorClosed, 1);
    check("areset_done", closeDone, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("areset_stays_closed", doorClosed, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
